// File: rtl/nv_ram_rws_128x32_fifo_ctrl_pkg.sv
// rtl/nv_ram_rws_128x32_fifo_ctrl_pkg.sv - shared defaults, types and helpers for the RAM FIFO controller
// Contents: FIFO_DEPTH/FIFO_AW/FIFO_DW defaults, obuf_cnt_t, obuf_has_room() issue-gate helper.
package nv_ram_rws_128x32_fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 128;
    localparam int FIFO_AW    = 7;
    localparam int FIFO_DW    = 32;

    // Occupancy of the 2-entry output buffer: 0, 1 or 2.
    typedef logic [1:0] obuf_cnt_t;

    // A RAM read may be issued only if the word it returns will find a free
    // obuf slot: words held plus the word already in flight, minus the word
    // leaving this cycle, must stay below the buffer size.
    function automatic logic obuf_has_room(input obuf_cnt_t cnt,
                                           input logic      inflight,
                                           input logic      pop);
        logic [2:0] occ;
        occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/nv_ram_fifo_obuf.sv
// rtl/nv_ram_fifo_obuf.sv - 2-entry in-order registered output buffer fed by RAM read data
// Ports: clk, rst_n (async active-low), clr (sync drop-all), load/din (append at tail),
//        pop (remove head), cnt (occupancy), vld (cnt!=0), dout (registered head word).
module nv_ram_fifo_obuf
    import nv_ram_rws_128x32_fifo_ctrl_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output obuf_cnt_t     cnt,
    output logic          vld,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] d0;  // head
    logic [DW-1:0] d1;  // second entry, valid only when cnt==2

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            d0  <= '0;
            d1  <= '0;
        end else if (clr) begin
            cnt <= 2'd0;
            d0  <= '0;
        end else begin
            unique case (cnt)
                2'd0: begin
                    if (load) begin
                        d0  <= din;
                        cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    // Load+pop replaces the head in place so throughput stays 1/clk.
                    if (load && pop) begin
                        d0 <= din;
                    end else if (load) begin
                        d1  <= din;
                        cnt <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    // The issue gate never lets a load arrive here without a pop;
                    // the load branch only keeps the buffer consistent if it did.
                    if (pop) begin
                        d0 <= d1;
                        if (load) begin
                            d1 <= din;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign vld  = (cnt != 2'd0);
    assign dout = d0;

endmodule

// File: rtl/nv_ram_rws_128x32_fifo_ctrl.sv
// rtl/nv_ram_rws_128x32_fifo_ctrl.sv - sync FIFO controller around a 128x32 1R1W RAM with 2-word prefetch
// Ports: nvdla_core_clk/nvdla_core_rstn (async active-low), clr; producer wr_pvld/wr_prdy/wr_pd;
//        consumer rd_pvld/rd_prdy/rd_pd (registered); idle; RAM drive ram_ra/re/wa/we/di, ram_dout;
//        pwrbus_ram_pd passed to ram_pwrbus_pd.
module nv_ram_rws_128x32_fifo_ctrl
    import nv_ram_rws_128x32_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          clr,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          idle,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_pd
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;   // words in RAM not yet read-issued
    logic          inflight;  // a read was issued last cycle; ram_dout is valid now
    obuf_cnt_t     obuf_cnt;
    logic          ram_full;
    logic          push;
    logic          pop;

    assign ram_full = (ram_cnt == (AW+1)'(DEPTH));
    assign wr_prdy  = ~ram_full;

    // Writes are suppressed during clr and while reset is held so the RAM
    // never sees a write that the controller state will not account for.
    assign push = wr_pvld & wr_prdy & ~clr & nvdla_core_rstn;
    assign pop  = rd_pvld & rd_prdy;

    // ram_cnt only counts entries written at a previous edge, so a read can
    // never target the slot being written in the same cycle.
    assign ram_re = ~clr & (ram_cnt != '0) & obuf_has_room(obuf_cnt, inflight, pop);

    assign ram_ra        = rd_ptr;
    assign ram_wa        = wr_ptr;
    assign ram_we        = push;
    assign ram_di        = wr_pd;
    assign ram_pwrbus_pd = pwrbus_ram_pd;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            ram_cnt  <= ram_cnt + (AW+1)'(push) - (AW+1)'(ram_re);
            inflight <= ram_re;
        end
    end

    nv_ram_fifo_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .clr   (clr),
        .load  (inflight),
        .din   (ram_dout),
        .pop   (pop),
        .cnt   (obuf_cnt),
        .vld   (rd_pvld),
        .dout  (rd_pd)
    );

    assign idle = (ram_cnt == '0) & ~inflight & (obuf_cnt == 2'd0);

endmodule
